fp_mul_norm_round_pipe: RTL and testbench

//  Parametrised, pipelined post-multiply normaliser for the FP MAC datapath.
//  - Takes the raw significand product and the pre-normalisation exponent.
//  - Normalises on the leading one and rounds to nearest-even.
//  - Saturates overflow to infinity and flushes underflow to zero.
//  - Sits between the significand multiplier and the accumulator adder, with valid/ready on both sides.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_lead_one.sv | 22 ++
 rtl/fp_mul_norm_round_pipe.sv | 128 ++++++++++++
 tb/tb_fp_mul_norm_round_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP MAC datapath: flag positions, result packing
// and exponent helpers used by the multiplier and adder normalisers.
package fp_pkg;

  localparam int FP_MAN_W = 10;
  localparam int FP_EXP_W = 5;

  localparam int FLG_ZERO = 3;
  localparam int FLG_OVF  = 2;
  localparam int FLG_UNF  = 1;
  localparam int FLG_INX  = 0;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp_res_t;

  function automatic int unsigned exp_all_ones(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_lead_one.sv
// Combinational priority encoder: index of the most significant set bit.
// zero is raised when no bit is set; idx is then 0.
module fp_lead_one #(
  parameter int W = 22
) (
  input  logic [W-1:0]         a,
  output logic [$clog2(W)-1:0] idx,
  output logic                 zero
);

  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (a[i]) begin
        idx  = ($clog2(W))'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_mul_norm_round_pipe.sv
// Post-multiply normaliser: stage 1 aligns the product on its leading one,
// stage 2 rounds to nearest-even and applies overflow/underflow handling.
module fp_mul_norm_round_pipe
  import fp_pkg::*;
#(
  parameter int MAN_W = 10,
  parameter int EXP_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*(MAN_W+1)-1:0]    in_prod,
  input  logic [EXP_W+1:0]          in_exp,
  input  logic                      in_sign,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic [EXP_W-1:0]          out_exp,
  output logic [MAN_W-1:0]          out_man,
  output logic [3:0]                out_flags
);

  localparam int PW = 2*(MAN_W+1);
  localparam int IW = $clog2(PW);
  localparam int XW = EXP_W+2;

  logic           s2_ready;
  logic [IW-1:0]  lead_idx;
  logic           lead_zero;
  logic [XW-1:0]  e1_c;
  logic [PW-2:0]  norm_c;

  logic             s1_valid;
  logic             s1_sign;
  logic             s1_zero;
  logic [XW-1:0]    s1_exp;
  logic [MAN_W-1:0] s1_man;
  logic             s1_g;
  logic             s1_s;

  logic             round_up;
  logic [MAN_W:0]   man_inc;
  logic [XW:0]      e2_c;
  logic             ovf;
  logic             unf;
  logic [EXP_W-1:0] exp_c;
  logic [MAN_W-1:0] man_c;
  logic [3:0]       flags_c;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  fp_lead_one #(.W(PW)) u_lead_one (
    .a    (in_prod),
    .idx  (lead_idx),
    .zero (lead_zero)
  );

  // The leading one lands at bit PW-1 and is implicit, so it is dropped here.
  assign e1_c   = in_exp + XW'(lead_idx) - XW'(PW-2);
  assign norm_c = (PW-1)'(in_prod << (IW'(PW-1) - lead_idx));

  assign round_up = s1_g && (s1_s || s1_man[0]);
  assign man_inc  = {1'b0, s1_man} + (MAN_W+1)'(round_up);
  // One extra bit so the rounding carry cannot wrap the signed exponent.
  assign e2_c     = {s1_exp[XW-1], s1_exp} + (XW+1)'(man_inc[MAN_W]);
  assign ovf      = !e2_c[XW] && (e2_c[XW-1:0] >= XW'(exp_all_ones(EXP_W)));
  assign unf      = e2_c[XW] || (e2_c == '0);

  always_comb begin
    exp_c   = e2_c[EXP_W-1:0];
    man_c   = man_inc[MAN_W-1:0];
    flags_c = '0;
    if (s1_zero) begin
      exp_c             = '0;
      man_c             = '0;
      flags_c[FLG_ZERO] = 1'b1;
    end else if (ovf) begin
      exp_c            = EXP_W'(exp_all_ones(EXP_W));
      man_c            = '0;
      flags_c[FLG_OVF] = 1'b1;
      flags_c[FLG_INX] = 1'b1;
    end else if (unf) begin
      exp_c            = '0;
      man_c            = '0;
      flags_c[FLG_UNF] = 1'b1;
      flags_c[FLG_INX] = 1'b1;
    end else begin
      flags_c[FLG_INX] = s1_g || s1_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_exp    <= '0;
      s1_man    <= '0;
      s1_g      <= 1'b0;
      s1_s      <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
      out_flags <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sign <= in_sign;
        s1_zero <= lead_zero;
        s1_exp  <= e1_c;
        s1_man  <= norm_c[PW-2 -: MAN_W];
        s1_g    <= norm_c[PW-2-MAN_W];
        s1_s    <= |norm_c[PW-3-MAN_W:0];
      end
      if (s2_ready) out_valid <= s1_valid;
      if (s1_valid && s2_ready) begin
        out_sign  <= s1_sign;
        out_exp   <= exp_c;
        out_man   <= man_c;
        out_flags <= flags_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round_pipe.sv
// Bench for fp_mul_norm_round_pipe: directed corner cases, stall/reset
// handling and a randomized stream checked against an arithmetic reference.
module tb_fp_mul_norm_round_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_prod;
  logic [6:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [4:0]  out_exp;
  logic [9:0]  out_man;
  logic [3:0]  out_flags;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic        acc;
  logic        held_v = 1'b0;
  logic [19:0] held;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mul_norm_round_pipe #(.MAN_W(10), .EXP_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_flags (out_flags)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Real-valued view: value = prod * 2^(exp-20); keep 10 fraction bits below
  // the leading one and round the remainder against one half.
  function automatic logic [19:0] ref_model(input logic [21:0] p, input int e, input logic s);
    int     k;
    int     e2;
    int     man;
    int     rem;
    longint sc;
    if (p == 0) return {s, 5'd0, 10'd0, 4'b1000};
    k = 0;
    for (int i = 0; i < 22; i++) if (p[i]) k = i;
    e2  = e + k - 20;
    sc  = longint'(p) << (21 - k);
    man = int'((sc >> 11) & 1023);
    rem = int'(sc & 2047);
    if (rem > 1024 || (rem == 1024 && (man % 2) == 1)) begin
      man = man + 1;
      if (man == 1024) begin
        man = 0;
        e2  = e2 + 1;
      end
    end
    if (e2 >= 31) return {s, 5'd31, 10'd0, 4'b0101};
    if (e2 <= 0)  return {s, 5'd0, 10'd0, 4'b0011};
    return {s, 5'(e2), 10'(man), 3'b000, (rem != 0)};
  endfunction

  task automatic cycle(input logic v, input logic [21:0] p, input int e, input logic s,
                       input logic ordy);
    logic [19:0] cur;
    logic [19:0] w;
    @(negedge clk);
    in_valid  = v;
    in_prod   = p;
    in_exp    = 7'(e);
    in_sign   = s;
    out_ready = ordy;
    #1;
    cur = {out_sign, out_exp, out_man, out_flags};
    if (held_v && out_valid) chk("hold_stable", cur, held);
    held_v = out_valid && !out_ready;
    held   = cur;
    acc = v && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        w = exp_q.pop_front();
        chk("result", cur, w);
      end
    end
    if (acc) exp_q.push_back(ref_model(p, e, s));
    @(posedge clk);
  endtask

  task automatic directed(input string tag, input logic [21:0] p, input int e, input logic s,
                          input logic [19:0] want);
    @(negedge clk);
    in_valid  = 1'b1;
    in_prod   = p;
    in_exp    = 7'(e);
    in_sign   = s;
    out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, {out_sign, out_exp, out_man, out_flags}, want);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [21:0] bp[5];
    int          be[5];
    logic        bs[5];
    int          bi;
    int          guard;
    int          n_acc;
    logic        have;
    logic [21:0] rp;
    int          re;
    logic        rs;
    logic [10:0] a;
    logic [10:0] b;

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_exp = '0; in_sign = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {out_sign, out_exp, out_man, out_flags}, 0);
    @(negedge clk) rst = 1'b0;

    directed("norm_lo",   22'h100000, 15, 1'b0, {1'b0, 5'd15, 10'h000, 4'b0000});
    directed("norm_hi",   22'h200000, 15, 1'b0, {1'b0, 5'd16, 10'h000, 4'b0000});
    directed("rnd_carry", 22'h1FFE00, 15, 1'b0, {1'b0, 5'd16, 10'h000, 4'b0001});
    directed("tie_even",  22'h100200, 15, 1'b0, {1'b0, 5'd15, 10'h000, 4'b0001});
    directed("tie_odd",   22'h100600, 15, 1'b0, {1'b0, 5'd15, 10'h002, 4'b0001});
    directed("overflow",  22'h200000, 30, 1'b0, {1'b0, 5'd31, 10'h000, 4'b0101});
    directed("underflow", 22'h000800, 5,  1'b0, {1'b0, 5'd0,  10'h000, 4'b0011});
    directed("zero",      22'h000000, 20, 1'b1, {1'b1, 5'd0,  10'h000, 4'b1000});
    directed("neg_norm",  22'h155555, 10, 1'b1, ref_model(22'h155555, 10, 1'b1));
    idle(3);

    // Stall: five beats against a blocked output.
    for (int i = 0; i < 5; i++) begin
      bp[i] = 22'h100000 | 22'($urandom_range(0, 22'hFFFFF));
      be[i] = int'($urandom_range(5, 25));
      bs[i] = 1'($urandom_range(0, 1));
    end
    n_out = 0;
    bi    = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, bp[bi], be[bi], bs[bi], 1'b0);
      if (acc) bi++;
    end
    chk("stall_accepted", bi, 2);
    @(negedge clk);
    #1 chk("stall_in_ready", in_ready, 0);
    guard = 0;
    while ((bi < 5 || exp_q.size() > 0) && guard < 40) begin
      cycle(bi < 5, bp[bi < 5 ? bi : 0], be[bi < 5 ? bi : 0], bs[bi < 5 ? bi : 0], 1'b1);
      if (acc) bi++;
      guard++;
    end
    chk("stall_out_count", n_out, 5);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Random stream with random back-pressure.
    n_acc = 0;
    guard = 0;
    have  = 1'b0;
    rp = '0; re = 0; rs = 1'b0;
    while (n_acc < 1000 && guard < 20000) begin
      if (!have) begin
        case ($urandom_range(0, 9))
          0:       rp = '0;
          1:       rp = 22'($urandom_range(1, 4095));
          2, 3:    rp = 22'($urandom);
          default: begin
            a  = 11'h400 | 11'($urandom_range(0, 1023));
            b  = 11'h400 | 11'($urandom_range(0, 1023));
            rp = 22'(a) * 22'(b);
          end
        endcase
        re   = int'($urandom_range(0, 45)) - 10;
        rs   = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      cycle($urandom_range(0, 3) != 0, rp, re, rs, 1'($urandom_range(0, 1)));
      if (acc) begin
        n_acc++;
        have = 1'b0;
      end
      guard++;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      cycle(1'b0, '0, 0, 1'b0, 1'b1);
      guard++;
    end
    chk("rand_accepted", n_acc, 1000);
    chk("rand_drain", exp_q.size(), 0);
    idle(2);

    // Reset with two beats in flight.
    cycle(1'b1, 22'h180000, 12, 1'b0, 1'b0);
    cycle(1'b1, 22'h1C0000, 13, 1'b1, 1'b0);
    @(negedge clk) rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    held_v = 1'b0;
    @(negedge clk) rst = 1'b0;
    directed("post_rst", 22'h100000, 15, 1'b0, {1'b0, 5'd15, 10'h000, 4'b0000});
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
